// File: rtl/binary_to_bcd_param.sv
// ============================================================================
// Module   : binary_to_bcd_param
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per
//            clock, optional two's-complement input, sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_bcd_param #(
  parameter int INPUT_WIDTH    = 13,
  parameter int DECIMAL_DIGITS = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [INPUT_WIDTH-1:0]        i_Binary,
  input  logic                          i_Signed,
  input  logic                          i_Start,
  output logic [4*DECIMAL_DIGITS-1:0]   o_BCD,
  output logic                          o_Sign,
  output logic                          o_Overflow,
  output logic                          o_Busy,
  output logic                          o_DV
);

  localparam int c_CNT_W = $clog2(INPUT_WIDTH + 1);
  localparam int c_BCD_W = 4 * DECIMAL_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [INPUT_WIDTH-1:0]   r_mag;
  logic [c_BCD_W-1:0]       r_bcd;
  logic [c_CNT_W-1:0]       r_count;
  logic                     r_sign;
  logic                     r_ovf;

  logic                     w_neg;
  logic [INPUT_WIDTH-1:0]   w_mag_in;
  logic [c_BCD_W-1:0]       w_adj;
  logic [c_BCD_W:0]         w_shift;
  logic                     w_last;

  assign w_neg    = i_Signed & i_Binary[INPUT_WIDTH-1];
  assign w_mag_in = w_neg ? ((~i_Binary) + {{(INPUT_WIDTH-1){1'b0}}, 1'b1}) : i_Binary;
  assign w_last   = (r_count == c_CNT_W'(INPUT_WIDTH - 1));

  // add-3 correction applied to every digit in parallel before the shift
  generate
    for (genvar d = 0; d < DECIMAL_DIGITS; d++) begin : g_digit
      always_comb begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4];
        if (r_bcd[4*d +: 4] > 4'd4)
          w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  endgenerate

  // bit c_BCD_W is what falls out of the top digit
  assign w_shift = {w_adj, r_mag[INPUT_WIDTH-1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_Start) w_next = S_CONVERT;
      S_CONVERT: if (w_last)  w_next = S_DONE;
      S_DONE:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_count    <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      o_BCD      <= '0;
      o_Sign     <= 1'b0;
      o_Overflow <= 1'b0;
      o_DV       <= 1'b0;
    end else begin
      r_state <= w_next;
      o_DV    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_sign  <= w_neg;
            r_mag   <= w_mag_in;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
          end
        end
        S_CONVERT: begin
          r_bcd   <= w_shift[c_BCD_W-1:0];
          r_ovf   <= r_ovf | w_shift[c_BCD_W];
          r_mag   <= r_mag << 1;
          r_count <= r_count + 1'b1;
        end
        S_DONE: begin
          o_BCD      <= r_bcd;
          // a zero magnitude is exactly an all-zero result with no overflow
          o_Sign     <= r_sign & ~((r_bcd == '0) & ~r_ovf);
          o_Overflow <= r_ovf;
          o_DV       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_Busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_param.sv
// ============================================================================
// Module   : tb_binary_to_bcd_param
// Brief    : Self-checking bench for binary_to_bcd_param (default and 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_to_bcd_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] bin13 = '0;
  logic        sgn13 = 1'b0;
  logic        st13 = 1'b0;
  logic [15:0] bcd13;
  logic        sg13, ov13, busy13, dv13;

  logic [15:0] bin16 = '0;
  logic        sgn16 = 1'b0;
  logic        st16 = 1'b0;
  logic [15:0] bcd16;
  logic        sg16, ov16, busy16, dv16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  binary_to_bcd_param #(.INPUT_WIDTH(13), .DECIMAL_DIGITS(4)) dut13 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin13), .i_Signed(sgn13), .i_Start(st13),
    .o_BCD(bcd13), .o_Sign(sg13), .o_Overflow(ov13), .o_Busy(busy13), .o_DV(dv13));

  binary_to_bcd_param #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) dut16 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin16), .i_Signed(sgn16), .i_Start(st16),
    .o_BCD(bcd16), .o_Sign(sg16), .o_Overflow(ov16), .o_Busy(busy16), .o_DV(dv16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // decimal digits of m, low digit first, by plain division
  function automatic logic [15:0] ref_bcd(input longint unsigned m);
    logic [15:0] r;
    longint unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic longint unsigned ref_mag13(input logic [12:0] b, input logic s);
    if (s && b[12]) return 64'd8192 - 64'(b);
    return 64'(b);
  endfunction

  task automatic conv13(input logic [12:0] b, input logic s);
    longint unsigned m;
    int n, busy_cnt;
    m = ref_mag13(b, s);
    @(negedge clk);
    bin13 = b; sgn13 = s; st13 = 1'b1;
    @(posedge clk); #1;
    st13 = 1'b0;
    n = 0; busy_cnt = 0;
    while (!dv13 && n < 40) begin
      if (busy13) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk("latency13", 64'(n), 64'd14);
    chk("busy13_cycles", 64'(busy_cnt), 64'd14);
    chk("bcd13", 64'(bcd13), 64'(ref_bcd(m)));
    chk("sign13", 64'(sg13), 64'((s && b[12]) && m != 0));
    chk("ovf13", 64'(ov13), 64'(m >= 10000));
    @(posedge clk); #1;
    chk("dv13_pulse", 64'(dv13), 64'd0);
  endtask

  task automatic conv16(input logic [15:0] b);
    int n;
    @(negedge clk);
    bin16 = b; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    n = 0;
    while (!dv16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency16", 64'(n), 64'd17);
    chk("bcd16", 64'(bcd16), 64'(ref_bcd(64'(b) % 10000)));
    chk("ovf16", 64'(ov16), 64'(b >= 16'd10000));
    chk("sign16", 64'(sg16), 64'd0);
  endtask

  initial begin : main
    int n;
    logic [12:0] rb;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 64'(bcd13), 64'd0);
    chk("rst_flags", 64'({sg13, ov13, busy13, dv13}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed corner values
    conv13(13'd8191, 1'b0);
    conv13(13'h1FFF, 1'b1);
    conv13(13'h1000, 1'b1);
    conv13(13'd0,    1'b1);
    conv13(13'h1FFF, 1'b0);
    conv13(13'd9,    1'b0);

    conv16(16'd54321);
    conv16(16'd9999);
    conv16(16'd10000);
    conv16(16'd65535);

    // start held high, mid-conversion change ignored, restart after DONE
    @(negedge clk);
    bin13 = 13'd1234; sgn13 = 1'b0; st13 = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    bin13 = 13'd555;
    n = 5;
    while (!dv13 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_latency", 64'(n), 64'd14);
    chk("held_bcd1", 64'(bcd13), 64'h1234);
    @(posedge clk); #1;
    st13 = 1'b0;
    chk("held_busy_restart", 64'(busy13), 64'd1);
    chk("held_dv_once", 64'(dv13), 64'd0);
    n = 0;
    while (!dv13 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_latency2", 64'(n), 64'd14);
    chk("held_bcd2", 64'(bcd13), 64'h0555);
    @(posedge clk); #1;
    chk("held_dv_end", 64'(dv13), 64'd0);

    // abort by reset five cycles into a conversion
    conv13(13'h1FFF, 1'b1);
    @(negedge clk);
    bin13 = 13'd777; st13 = 1'b1;
    @(posedge clk); #1;
    st13 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_bcd", 64'(bcd13), 64'd0);
    chk("abort_flags", 64'({sg13, ov13, busy13, dv13}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dv13) n++;
    end
    chk("abort_no_dv", 64'(n), 64'd0);
    conv13(13'd42, 1'b0);

    // randomized values in both modes
    for (int i = 0; i < 150; i++) begin
      rb = 13'($urandom_range(0, 8191));
      conv13(rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
